// File: rtl/satisfaction_streak_monitor.sv
// Tracks consecutive satisfied/unsatisfied samples of the satisfaction detector
// and classifies the current mood (NEUTRAL / CONTENT / DESPAIR).
module satisfaction_streak_monitor #(
  parameter int CONTENT_LEN = 4,
  parameter int DESPAIR_LEN = 3,
  parameter int CNT_W       = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Sample_Valid,
  input  logic             Has_Satisfaction,
  input  logic             Clear,
  output logic             Is_Content,
  output logic             Is_Despairing,
  output logic [CNT_W-1:0] Streak_Count,
  output logic [CNT_W-1:0] Best_Streak,
  output logic             Mood_Changed
);

  typedef enum logic [1:0] {
    NEUTRAL = 2'd0,
    CONTENT = 2'd1,
    DESPAIR = 2'd2
  } mood_t;

  localparam logic [CNT_W-1:0] CONTENT_THR = CNT_W'(CONTENT_LEN);
  localparam logic [CNT_W-1:0] DESPAIR_THR = CNT_W'(DESPAIR_LEN);

  mood_t            state_p0, state_nxt;
  logic [CNT_W-1:0] streak_p0, streak_nxt;
  logic [CNT_W-1:0] miss_p0, miss_nxt;
  logic [CNT_W-1:0] best_p0, best_nxt;
  logic             chg_p0, chg_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Counter update and next-mood decision from the post-update counts
  always_comb begin
    streak_nxt = streak_p0;
    miss_nxt   = miss_p0;
    best_nxt   = best_p0;
    state_nxt  = state_p0;
    if (Clear) begin
      streak_nxt = '0;
      miss_nxt   = '0;
      state_nxt  = NEUTRAL;
    end else if (Sample_Valid) begin
      if (Has_Satisfaction) begin
        streak_nxt = sat_inc(streak_p0);
        miss_nxt   = '0;
      end else begin
        streak_nxt = '0;
        miss_nxt   = sat_inc(miss_p0);
      end
      if (streak_nxt >= CONTENT_THR)    state_nxt = CONTENT;
      else if (miss_nxt >= DESPAIR_THR) state_nxt = DESPAIR;
      else                              state_nxt = NEUTRAL;
      if (streak_nxt > best_p0) best_nxt = streak_nxt;
    end
    chg_nxt = (state_nxt != state_p0);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_p0  <= NEUTRAL;
      streak_p0 <= '0;
      miss_p0   <= '0;
      best_p0   <= '0;
      chg_p0    <= 1'b0;
    end else begin
      state_p0  <= state_nxt;
      streak_p0 <= streak_nxt;
      miss_p0   <= miss_nxt;
      best_p0   <= best_nxt;
      chg_p0    <= chg_nxt;
    end
  end

  assign Is_Content    = (state_p0 == CONTENT);
  assign Is_Despairing = (state_p0 == DESPAIR);
  assign Streak_Count  = streak_p0;
  assign Best_Streak   = best_p0;
  assign Mood_Changed  = chg_p0;

endmodule

// File: tb/tb_satisfaction_streak_monitor.sv
// Directed bench for satisfaction_streak_monitor (default instance plus a CNT_W=4 instance).
module tb_satisfaction_streak_monitor;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Sample_Valid = 1'b0;
  logic       Has_Satisfaction = 1'b0;
  logic       Clear = 1'b0;
  logic       Is_Content, Is_Despairing, Mood_Changed;
  logic [7:0] Streak_Count, Best_Streak;

  logic       sv2 = 1'b0, hs2 = 1'b0, clr2 = 1'b0;
  logic       content2, despair2, chg2;
  logic [3:0] streak2, best2;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  satisfaction_streak_monitor dut (
    .Clock(Clock), .Reset(Reset), .Sample_Valid(Sample_Valid),
    .Has_Satisfaction(Has_Satisfaction), .Clear(Clear),
    .Is_Content(Is_Content), .Is_Despairing(Is_Despairing),
    .Streak_Count(Streak_Count), .Best_Streak(Best_Streak),
    .Mood_Changed(Mood_Changed)
  );

  satisfaction_streak_monitor #(.CONTENT_LEN(4), .DESPAIR_LEN(3), .CNT_W(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .Sample_Valid(sv2),
    .Has_Satisfaction(hs2), .Clear(clr2),
    .Is_Content(content2), .Is_Despairing(despair2),
    .Streak_Count(streak2), .Best_Streak(best2),
    .Mood_Changed(chg2)
  );

  // One clock of stimulus on the default instance; outputs are settled 1ns after the edge.
  task automatic step(input logic v, input logic h, input logic c);
    Sample_Valid = v; Has_Satisfaction = h; Clear = c;
    @(posedge Clock); #1;
    Sample_Valid = 1'b0; Has_Satisfaction = 1'b0; Clear = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    checks++; if (Streak_Count !== 8'd0) begin failures++; $display("FAIL reset_streak got=%0d exp=0", Streak_Count); end
    checks++; if (Best_Streak !== 8'd0) begin failures++; $display("FAIL reset_best got=%0d exp=0", Best_Streak); end
    checks++; if ({Is_Content, Is_Despairing, Mood_Changed} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {Is_Content, Is_Despairing, Mood_Changed}); end
    checks++; if ({content2, despair2, chg2, streak2, best2} !== 11'd0) begin failures++; $display("FAIL reset_dut4 got=%h exp=0", {content2, despair2, chg2, streak2, best2}); end
    @(negedge Clock); Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_content_entry;
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++; if (Streak_Count !== 8'(i) || Is_Content !== 1'b0 || Mood_Changed !== 1'b0) begin
        failures++; $display("FAIL entry_pre%0d got streak=%0d content=%b chg=%b exp streak=%0d content=0 chg=0", i, Streak_Count, Is_Content, Mood_Changed, i);
      end
    end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (Streak_Count !== 8'd4) begin failures++; $display("FAIL entry_streak got=%0d exp=4", Streak_Count); end
    checks++; if (Is_Content !== 1'b1 || Is_Despairing !== 1'b0) begin failures++; $display("FAIL entry_state got content=%b despair=%b exp 1/0", Is_Content, Is_Despairing); end
    checks++; if (Best_Streak !== 8'd4) begin failures++; $display("FAIL entry_best got=%0d exp=4", Best_Streak); end
    checks++; if (Mood_Changed !== 1'b1) begin failures++; $display("FAIL entry_pulse got=%b exp=1", Mood_Changed); end
    step(1'b0, 1'b1, 1'b0);
    checks++; if (Mood_Changed !== 1'b0 || Is_Content !== 1'b1) begin failures++; $display("FAIL entry_pulse_end got chg=%b content=%b exp 0/1", Mood_Changed, Is_Content); end
  endtask

  task automatic test_idle_gap;
    step(1'b0, 1'b0, 1'b1);
    checks++; if (Is_Content !== 1'b0 || Streak_Count !== 8'd0 || Mood_Changed !== 1'b1) begin
      failures++; $display("FAIL gap_clear got content=%b streak=%0d chg=%b exp 0/0/1", Is_Content, Streak_Count, Mood_Changed);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, (i % 2 == 0), 1'b0);
    checks++; if (Streak_Count !== 8'd2 || Mood_Changed !== 1'b0) begin failures++; $display("FAIL gap_hold got streak=%0d chg=%b exp 2/0", Streak_Count, Mood_Changed); end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++; if (Streak_Count !== 8'd4 || Is_Content !== 1'b1 || Mood_Changed !== 1'b1) begin
      failures++; $display("FAIL gap_content got streak=%0d content=%b chg=%b exp 4/1/1", Streak_Count, Is_Content, Mood_Changed);
    end
    checks++; if (Best_Streak !== 8'd4) begin failures++; $display("FAIL gap_best got=%0d exp=4", Best_Streak); end
  endtask

  task automatic test_despair;
    step(1'b1, 1'b0, 1'b0);
    checks++; if (Is_Content !== 1'b0 || Is_Despairing !== 1'b0 || Mood_Changed !== 1'b1 || Streak_Count !== 8'd0) begin
      failures++; $display("FAIL despair_miss1 got content=%b despair=%b chg=%b streak=%0d exp 0/0/1/0", Is_Content, Is_Despairing, Mood_Changed, Streak_Count);
    end
    step(1'b1, 1'b0, 1'b0);
    checks++; if (Is_Despairing !== 1'b0 || Mood_Changed !== 1'b0) begin failures++; $display("FAIL despair_miss2 got despair=%b chg=%b exp 0/0", Is_Despairing, Mood_Changed); end
    step(1'b1, 1'b0, 1'b0);
    checks++; if (Is_Despairing !== 1'b1 || Is_Content !== 1'b0 || Mood_Changed !== 1'b1 || Streak_Count !== 8'd0) begin
      failures++; $display("FAIL despair_enter got despair=%b content=%b chg=%b streak=%0d exp 1/0/1/0", Is_Despairing, Is_Content, Mood_Changed, Streak_Count);
    end
    step(1'b1, 1'b0, 1'b0);
    checks++; if (Is_Despairing !== 1'b1 || Mood_Changed !== 1'b0) begin failures++; $display("FAIL despair_stay got despair=%b chg=%b exp 1/0", Is_Despairing, Mood_Changed); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (Is_Despairing !== 1'b0 || Is_Content !== 1'b0 || Streak_Count !== 8'd1 || Mood_Changed !== 1'b1) begin
      failures++; $display("FAIL despair_exit got despair=%b content=%b streak=%0d chg=%b exp 0/0/1/1", Is_Despairing, Is_Content, Streak_Count, Mood_Changed);
    end
  endtask

  task automatic test_saturation;
    int late_pulses;
    late_pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      sv2 = 1'b1; hs2 = 1'b1;
      @(posedge Clock); #1;
      sv2 = 1'b0; hs2 = 1'b0;
      if (i == 4) begin
        checks++; if (content2 !== 1'b1 || chg2 !== 1'b1) begin failures++; $display("FAIL sat_entry got content=%b chg=%b exp 1/1", content2, chg2); end
      end
      if (i > 4 && chg2 !== 1'b0) late_pulses++;
    end
    checks++; if (streak2 !== 4'd15) begin failures++; $display("FAIL sat_streak got=%0d exp=15", streak2); end
    checks++; if (best2 !== 4'd15) begin failures++; $display("FAIL sat_best got=%0d exp=15", best2); end
    checks++; if (content2 !== 1'b1 || despair2 !== 1'b0) begin failures++; $display("FAIL sat_state got content=%b despair=%b exp 1/0", content2, despair2); end
    checks++; if (late_pulses != 0) begin failures++; $display("FAIL sat_no_pulse got=%0d exp=0", late_pulses); end
  endtask

  task automatic test_clear_priority;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    checks++; if (Streak_Count !== 8'd6 || Best_Streak !== 8'd6 || Is_Content !== 1'b1) begin
      failures++; $display("FAIL clr_setup got streak=%0d best=%0d content=%b exp 6/6/1", Streak_Count, Best_Streak, Is_Content);
    end
    step(1'b1, 1'b1, 1'b1);
    checks++; if (Is_Content !== 1'b0 || Is_Despairing !== 1'b0 || Streak_Count !== 8'd0) begin
      failures++; $display("FAIL clr_state got content=%b despair=%b streak=%0d exp 0/0/0", Is_Content, Is_Despairing, Streak_Count);
    end
    checks++; if (Best_Streak !== 8'd6) begin failures++; $display("FAIL clr_best got=%0d exp=6", Best_Streak); end
    checks++; if (Mood_Changed !== 1'b1) begin failures++; $display("FAIL clr_pulse got=%b exp=1", Mood_Changed); end
    step(1'b0, 1'b0, 1'b1);
    checks++; if (Mood_Changed !== 1'b0) begin failures++; $display("FAIL clr_neutral_nopulse got=%b exp=0", Mood_Changed); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (Streak_Count !== 8'd1) begin failures++; $display("FAIL clr_discard got=%0d exp=1", Streak_Count); end
  endtask

  task automatic test_async_reset;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    checks++; if (Streak_Count !== 8'd3) begin failures++; $display("FAIL ar_setup got=%0d exp=3", Streak_Count); end
    Sample_Valid = 1'b1; Has_Satisfaction = 1'b1;
    #2 Reset = 1'b1;
    #1;
    checks++; if (Streak_Count !== 8'd0 || Best_Streak !== 8'd0) begin failures++; $display("FAIL ar_counts got streak=%0d best=%0d exp 0/0", Streak_Count, Best_Streak); end
    checks++; if ({Is_Content, Is_Despairing, Mood_Changed} !== 3'b000) begin failures++; $display("FAIL ar_flags got=%b exp=000", {Is_Content, Is_Despairing, Mood_Changed}); end
    @(posedge Clock); #1;
    Sample_Valid = 1'b0; Has_Satisfaction = 1'b0;
    checks++; if (Streak_Count !== 8'd0) begin failures++; $display("FAIL ar_hold got=%0d exp=0", Streak_Count); end
    @(negedge Clock); Reset = 1'b0;
    @(posedge Clock); #1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    checks++; if (Is_Content !== 1'b0) begin failures++; $display("FAIL ar_pre_content got=%b exp=0", Is_Content); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (Is_Content !== 1'b1 || Streak_Count !== 8'd4 || Best_Streak !== 8'd4 || Mood_Changed !== 1'b1) begin
      failures++; $display("FAIL ar_recontent got content=%b streak=%0d best=%0d chg=%b exp 1/4/4/1", Is_Content, Streak_Count, Best_Streak, Mood_Changed);
    end
  endtask

  initial begin
    test_reset();
    test_content_entry();
    test_idle_gap();
    test_despair();
    test_saturation();
    test_clear_priority();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
